// File: rtl/triangle_edge_sequencer_pkg.sv
// Shared encodings for the triangle edge sequencer: FSM states, vertex slot
// indices and the default coordinate width.
package triangle_edge_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] X0 = 3'd0;
  localparam logic [2:0] Y0 = 3'd1;
  localparam logic [2:0] X1 = 3'd2;
  localparam logic [2:0] Y1 = 3'd3;
  localparam logic [2:0] X2 = 3'd4;
  localparam logic [2:0] Y2 = 3'd5;

  localparam int COORD_W_DEF = 10;

endpackage

// File: rtl/triangle_edge_sequencer.sv
// Fetches x0,y0,x1,y1,x2,y2 from a combinational vertex ROM and issues the
// triangle's three edges (V0-V1, V1-V2, V2-V0) as valid/ready line commands.
module triangle_edge_sequencer
  import triangle_edge_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               busy,
  output logic               done,
  output logic               coord_ovf,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [COORD_W-1:0] line_x0,
  output logic [COORD_W-1:0] line_y0,
  output logic [COORD_W-1:0] line_x1,
  output logic [COORD_W-1:0] line_y1
);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [2:0]          r_k;
  logic [1:0]          r_e;
  logic [COORD_W-1:0]  r_vtx [6];
  logic                r_ovf;
  logic                w_hs;
  logic [2:0]          w_sa, w_sb;

  assign w_hs = line_valid && line_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (r_k == 3'd5) w_next = S_EMIT;
      S_EMIT:  if (w_hs && r_e == 2'd2) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
      r_k    <= '0;
      r_e    <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < 6; i++) r_vtx[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_base <= base_addr;
          r_ovf  <= 1'b0;
          r_k    <= '0;
        end
        S_FETCH: begin
          r_vtx[r_k] <= rom_data[COORD_W-1:0];
          if (|rom_data[DATA_W-1:COORD_W]) r_ovf <= 1'b1;
          r_k <= r_k + 3'd1;
          r_e <= '0;
        end
        S_EMIT: if (w_hs) r_e <= r_e + 2'd1;
        default: ;
      endcase
    end
  end

  // Edge e runs from vertex e to vertex (e+1) mod 3; each vertex is an x,y slot pair.
  always_comb begin
    w_sa = X0;
    w_sb = X1;
    case (r_e)
      2'd0:    begin w_sa = X0; w_sb = X1; end
      2'd1:    begin w_sa = X1; w_sb = X2; end
      default: begin w_sa = X2; w_sb = X0; end
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    line_valid = (r_state == S_EMIT);
    coord_ovf  = r_ovf;
    rom_addr   = (r_state == S_FETCH) ? r_base + ADDR_W'(r_k) : '0;
    line_x0    = '0;
    line_y0    = '0;
    line_x1    = '0;
    line_y1    = '0;
    if (r_state == S_EMIT) begin
      line_x0 = r_vtx[w_sa];
      line_y0 = r_vtx[w_sa + 3'd1];
      line_x1 = r_vtx[w_sb];
      line_y1 = r_vtx[w_sb + 3'd1];
    end
  end

endmodule
